// File: rtl/cv32e40p_sleep_pwr_ctrl.sv
// cv32e40p_sleep_pwr_ctrl: settle-qualified sleep and 4-phase power-down handshake with the SoC power manager
module cv32e40p_sleep_pwr_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk_ungated_i,
    input  logic       rst_i,
    input  logic       fetch_enable_i,
    input  logic       core_sleep_i,
    input  logic       irq_pending_i,
    input  logic       debug_req_i,
    output logic       pwr_req_o,
    input  logic       pwr_ack_i,
    output logic       clk_off_o,
    output logic       wake_o,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {RUN = 3'd0, SETTLE = 3'd1, REQ = 3'd2, OFF = 3'd3, WAKE = 3'd4} state_e;
    localparam logic [7:0] SC = 8'(SETTLE_CYCLES);
    state_e     state, nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       wake_event, sleep_ok;
    assign wake_event = irq_pending_i | debug_req_i;
    assign sleep_ok   = fetch_enable_i & core_sleep_i & ~wake_event;
    assign state_o    = state;
    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            RUN: begin
                cnt_nxt = sleep_ok ? 8'd1 : 8'd0;
                if (sleep_ok) nxt = (SC == 8'd1) ? REQ : SETTLE;
            end
            SETTLE: begin
                cnt_nxt = !sleep_ok ? 8'd0 : (cnt < SC) ? cnt + 8'd1 : cnt;
                if (!sleep_ok) nxt = RUN;
                else if (cnt + 8'd1 == SC) nxt = REQ;
            end
            // once requested, the handshake must complete before any wake is honoured
            REQ:     if (pwr_ack_i) nxt = OFF;
            OFF:     if (wake_event | ~core_sleep_i) nxt = WAKE;
            WAKE:    if (!pwr_ack_i) nxt = RUN;
            default: nxt = RUN;
        endcase
    end
    always_ff @(posedge clk_ungated_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RUN;
            cnt       <= 8'd0;
            pwr_req_o <= 1'b0;
            clk_off_o <= 1'b0;
            wake_o    <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_nxt;
            pwr_req_o <= (nxt == REQ) || (nxt == OFF);
            clk_off_o <= nxt == OFF;
            wake_o    <= (state == WAKE) && (nxt == RUN);
        end
    end
endmodule

// File: tb/tb_cv32e40p_sleep_pwr_ctrl.sv
// tb_cv32e40p_sleep_pwr_ctrl: directed bench for the sleep power controller (SETTLE_CYCLES=4 and =1)
module tb_cv32e40p_sleep_pwr_ctrl;
    logic       clk = 1'b0;
    logic       rst, fetch, sleep, irq, dbg, ack;
    logic       req, clk_off, wake, req1, clk_off1, wake1;
    logic [2:0] st, st1;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    cv32e40p_sleep_pwr_ctrl #(.SETTLE_CYCLES(4)) dut (
        .clk_ungated_i(clk), .rst_i(rst), .fetch_enable_i(fetch), .core_sleep_i(sleep),
        .irq_pending_i(irq), .debug_req_i(dbg), .pwr_req_o(req), .pwr_ack_i(ack),
        .clk_off_o(clk_off), .wake_o(wake), .state_o(st)
    );

    cv32e40p_sleep_pwr_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk_ungated_i(clk), .rst_i(rst), .fetch_enable_i(fetch), .core_sleep_i(sleep),
        .irq_pending_i(irq), .debug_req_i(dbg), .pwr_req_o(req1), .pwr_ack_i(ack),
        .clk_off_o(clk_off1), .wake_o(wake1), .state_o(st1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic r, input logic c, input logic w, input logic [2:0] s);
        chk({tag, ".req"}, 8'(req), 8'(r));
        chk({tag, ".clk_off"}, 8'(clk_off), 8'(c));
        chk({tag, ".wake"}, 8'(wake), 8'(w));
        chk({tag, ".state"}, 8'(st), 8'(s));
    endtask

    initial begin
        rst = 1'b1; fetch = 1'b1; sleep = 1'b0; irq = 1'b0; dbg = 1'b0; ack = 1'b0;
        step(2);
        outs("reset", 0, 0, 0, 3'd0);
        rst = 1'b0;
        step();
        outs("idle", 0, 0, 0, 3'd0);

        // nominal sleep / irq wake
        sleep = 1'b1;
        step();
        outs("nom.e1", 0, 0, 0, 3'd1);
        chk("s1.req_e1", 8'(req1), 8'd1);
        chk("s1.state_e1", 8'(st1), 8'd2);
        step(2);
        outs("nom.e3", 0, 0, 0, 3'd1);
        step();
        outs("nom.e4", 1, 0, 0, 3'd2);
        step(2);
        outs("nom.wait_ack", 1, 0, 0, 3'd2);
        ack = 1'b1;
        step();
        outs("nom.off", 1, 1, 0, 3'd3);
        step(9);
        outs("nom.off_hold", 1, 1, 0, 3'd3);
        irq = 1'b1;
        step();
        outs("nom.wake_state", 0, 0, 0, 3'd4);
        irq = 1'b0; ack = 1'b0; sleep = 1'b0;
        step();
        outs("nom.wake_pulse", 0, 0, 1, 3'd0);
        step();
        outs("nom.wake_end", 0, 0, 0, 3'd0);

        // settle abort then fresh settle
        sleep = 1'b1;
        step(3);
        outs("abort.settle", 0, 0, 0, 3'd1);
        chk("abort.cnt3", dut.cnt, 8'd3);
        sleep = 1'b0;
        step();
        outs("abort.run", 0, 0, 0, 3'd0);
        chk("abort.cnt0", dut.cnt, 8'd0);
        sleep = 1'b1;
        step(3);
        outs("fresh.e3", 0, 0, 0, 3'd1);
        step();
        outs("fresh.e4", 1, 0, 0, 3'd2);
        ack = 1'b1;
        step();
        outs("fresh.off", 1, 1, 0, 3'd3);
        sleep = 1'b0;
        step();
        outs("fresh.wake", 0, 0, 0, 3'd4);
        ack = 1'b0;
        step();
        outs("fresh.pulse", 0, 0, 1, 3'd0);

        // fetch disabled
        fetch = 1'b0; sleep = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("fetch_off.req", 8'(req), 8'd0);
            chk("fetch_off.state", 8'(st), 8'd0);
        end

        // spurious ack in RUN and simultaneous wake/sleep rise
        fetch = 1'b1; sleep = 1'b0; ack = 1'b1;
        step();
        outs("proto_err", 0, 0, 0, 3'd0);
        ack = 1'b0; sleep = 1'b1; irq = 1'b1;
        step();
        outs("sleep_and_irq", 0, 0, 0, 3'd0);
        irq = 1'b0;

        // debug wake during REQ with delayed ack
        step(4);
        outs("dbg.req", 1, 0, 0, 3'd2);
        dbg = 1'b1;
        step(5);
        outs("dbg.hold", 1, 0, 0, 3'd2);
        ack = 1'b1;
        step();
        outs("dbg.off", 1, 1, 0, 3'd3);
        step();
        outs("dbg.wake", 0, 0, 0, 3'd4);
        ack = 1'b0;
        step();
        outs("dbg.pulse", 0, 0, 1, 3'd0);
        dbg = 1'b0; sleep = 1'b0;
        step();
        outs("dbg.after", 0, 0, 0, 3'd0);

        // async reset while OFF
        sleep = 1'b1;
        step(4);
        ack = 1'b1;
        step();
        outs("rst.off", 1, 1, 0, 3'd3);
        #2 rst = 1'b1;
        #1;
        outs("rst.async", 0, 0, 0, 3'd0);
        sleep = 1'b0; ack = 1'b0;
        step();
        rst = 1'b0;
        step();
        outs("rst.release", 0, 0, 0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
